// File: rtl/nibble_serial_sub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_sub_ctrl_if
// Brief   : Bundles the operand port, result port and shared-slice signals
//           of the nibble-serial subtract sequencer.
// Revision: 1.0  initial release
// ============================================================================
interface nibble_serial_sub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // operand port
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  // shared 4-bit slice
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_d;
  logic         slice_cout;

  // result port
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_zero;
  logic         out_ovf;

  // Controller view
  modport slave (
    input  in_valid, in_a, in_b, out_ready, slice_d, slice_cout,
    output in_ready, out_valid, out_diff, out_borrow, out_zero, out_ovf,
    output slice_a, slice_b, slice_cin
  );

  // Environment view: operand source, result sink and the slice itself
  modport master (
    output in_valid, in_a, in_b, out_ready, slice_d, slice_cout,
    input  in_ready, out_valid, out_diff, out_borrow, out_zero, out_ovf,
    input  slice_a, slice_b, slice_cin
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_sub_ctrl
// Brief   : Subtracts wide operands one nibble per cycle (LSB first) on a
//           shared external 4-bit a + ~b + cin slice, chaining the carry and
//           returning difference, borrow, zero and signed-overflow flags.
// Revision: 1.0  initial release
// ============================================================================
module nibble_serial_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nibble_serial_sub_ctrl_if.slave       bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     diff_acc;
  logic             borrow_flag;
  logic             zero_flag;
  logic             ovf_flag;

  logic             in_ready_c;
  logic             out_valid_c;
  logic [3:0]       slice_a_c;
  logic [3:0]       slice_b_c;
  logic             slice_cin_c;
  logic [W-1:0]     diff_next;
  logic             accept;
  logic             last_nibble;

  assign accept      = bus.in_valid & in_ready_c;
  assign last_nibble = (idx == LAST_IDX);

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, handshake and slice drive; the slice is idle (0,0,cin=1) outside RUN
  always_comb begin
    next_state  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    slice_a_c   = 4'h0;
    slice_b_c   = 4'h0;
    slice_cin_c = 1'b1;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        slice_a_c   = op_a[{idx, 2'b00} +: 4];
        slice_b_c   = op_b[{idx, 2'b00} +: 4];
        slice_cin_c = carry;
        if (last_nibble) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Difference with the current slice nibble merged in, so the flags can be
  // taken from the complete result on the last RUN cycle
  always_comb begin
    diff_next                      = diff_acc;
    diff_next[{idx, 2'b00} +: 4]   = bus.slice_d;
  end

  // Operand latch, nibble walk, carry chain and flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      carry       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      diff_acc    <= '0;
      borrow_flag <= 1'b0;
      zero_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        op_a  <= bus.in_a;
        op_b  <= bus.in_b;
        idx   <= '0;
        carry <= 1'b1;
      end else if (state == RUN) begin
        diff_acc <= diff_next;
        carry    <= bus.slice_cout;
        if (last_nibble) begin
          borrow_flag <= ~bus.slice_cout;
          zero_flag   <= (diff_next == '0);
          ovf_flag    <= (op_a[W-1] != op_b[W-1]) & (diff_next[W-1] != op_a[W-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.slice_a    = slice_a_c;
  assign bus.slice_b    = slice_b_c;
  assign bus.slice_cin  = slice_cin_c;
  assign bus.out_diff   = diff_acc;
  assign bus.out_borrow = borrow_flag;
  assign bus.out_zero   = zero_flag;
  assign bus.out_ovf    = ovf_flag;

endmodule
`default_nettype wire
